// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: memory stage driving a fixed-latency SRAM bus, stalling via SRAM_ready, plus the MEM/WB register.
// Define MEM_STAGE_WBUF_EN to post stores through a one-entry write buffer.
module mem_stage_pipe #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int DEST_W      = 4,
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              MEM_W_EN_IN,
    input  logic              MEM_R_EN_IN,
    input  logic              WB_EN_IN,
    input  logic [DATA_W-1:0] ALU_result_IN,
    input  logic [DATA_W-1:0] Val_Rm,
    input  logic [DATA_W-1:0] PC_IN,
    input  logic [DEST_W-1:0] Dest_IN,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] MEM_read_value,
    output logic [DATA_W-1:0] PC,
    output logic [DEST_W-1:0] Dest,
    output logic              SRAM_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata_q;
    logic              r_we;
    logic              w_req;
    logic              w_post;
    logic              w_drain;
    logic              w_last;
    logic              w_load;
    logic [ADDR_W-1:0] w_addr;

    assign w_req  = MEM_R_EN_IN | MEM_W_EN_IN;
    assign w_addr = ADDR_W'((ALU_result_IN - DATA_W'(BASE_ADDR)) >> 2);
    assign w_last = (r_state == ACCESS) && (r_cnt == 4'(WAIT_CYCLES - 1));

`ifdef MEM_STAGE_WBUF_EN
    logic r_wb_v;

    // A frozen store is not posted, otherwise it would be presented again and written twice.
    assign w_post  = MEM_W_EN_IN & ~r_wb_v & ~freeze;
    assign w_drain = r_wb_v;

    always_ff @(posedge clk) begin
        if (rst)
            r_wb_v <= 1'b0;
        else if (r_state == IDLE && w_post)
            r_wb_v <= 1'b1;
        else if (w_last)
            r_wb_v <= 1'b0;
    end
`else
    assign w_post  = 1'b0;
    assign w_drain = 1'b0;
`endif

    assign SRAM_ready = (r_state == DONE) || (r_state == IDLE && (!w_req || w_post));
    assign mem_req    = (r_state == ACCESS);
    assign mem_we     = mem_req & r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign w_load     = !freeze && SRAM_ready;

    // r_addr/r_wdata hold the access in flight; with posting they double as the write buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_rdata_q <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    r_state <= ACCESS;
                    r_cnt   <= '0;
                    r_addr  <= w_addr;
                    r_wdata <= Val_Rm;
                    r_we    <= MEM_W_EN_IN;
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_state <= w_drain ? IDLE : DONE;
                        if (!r_we) r_rdata_q <= mem_rdata;
                    end
                end
                DONE: if (!freeze) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WB_EN          <= 1'b0;
            MEM_R_EN       <= 1'b0;
            ALU_result     <= '0;
            MEM_read_value <= '0;
            PC             <= '0;
            Dest           <= '0;
        end else if (flush || w_load) begin
            WB_EN          <= WB_EN_IN & ~flush;
            MEM_R_EN       <= MEM_R_EN_IN & ~flush;
            ALU_result     <= ALU_result_IN;
            MEM_read_value <= MEM_R_EN_IN ? r_rdata_q : '0;
            PC             <= PC_IN;
            Dest           <= Dest_IN;
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed self-checking bench for mem_stage_pipe (default parameters).
// Expected store/load timing follows MEM_STAGE_WBUF_EN when it is defined.
module tb_mem_stage_pipe;
`ifdef MEM_STAGE_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, freeze, flush;
    logic        MEM_W_EN_IN, MEM_R_EN_IN, WB_EN_IN;
    logic [31:0] ALU_result_IN, Val_Rm, PC_IN;
    logic [3:0]  Dest_IN;
    logic        WB_EN, MEM_R_EN;
    logic [31:0] ALU_result, MEM_read_value, PC;
    logic [3:0]  Dest;
    logic        SRAM_ready, mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_fail = 0;
    int req_cycles = 0;
    logic [31:0] mem [0:15] = '{2: 32'hDEADBEEF, 3: 32'hCAFE0003, default: 32'h0};

    mem_stage_pipe dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .MEM_W_EN_IN(MEM_W_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .WB_EN_IN(WB_EN_IN),
        .ALU_result_IN(ALU_result_IN), .Val_Rm(Val_Rm), .PC_IN(PC_IN), .Dest_IN(Dest_IN),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
        .MEM_read_value(MEM_read_value), .PC(PC), .Dest(Dest),
        .SRAM_ready(SRAM_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_req) req_cycles <= req_cycles + 1;
        if (mem_req && mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic clr();
        freeze = 0; flush = 0; MEM_W_EN_IN = 0; MEM_R_EN_IN = 0; WB_EN_IN = 0;
        ALU_result_IN = 0; Val_Rm = 0; PC_IN = 0; Dest_IN = 0;
    endtask

    task automatic test_reset();
        clr(); MEM_R_EN_IN = 1; ALU_result_IN = 1032; rst = 1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
            n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
            n_chk++; if ({WB_EN, MEM_R_EN} !== 2'b00) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00", {WB_EN, MEM_R_EN}); end
            n_chk++; if (ALU_result !== 0 || MEM_read_value !== 0 || PC !== 0 || Dest !== 0) begin
                n_fail++; $display("FAIL reset_data: got %h %h %h %h expected all 0", ALU_result, MEM_read_value, PC, Dest);
            end
        end
        rst = 0; #1;
        n_chk++; if (SRAM_ready !== 1'b0) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 0", SRAM_ready); end
        @(posedge clk); #1;
        n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL post_reset_req: got %b expected 1", mem_req); end
        rst = 1; clr();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_blocking_read();
        clr(); MEM_R_EN_IN = 1; WB_EN_IN = 1; ALU_result_IN = 1032; PC_IN = 32'h100; Dest_IN = 4'd5;
        #1;
        n_chk++; if (SRAM_ready !== 1'b0) begin n_fail++; $display("FAIL rd_c0_ready: got %b expected 0", SRAM_ready); end
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_c%0d_req: got req=%b we=%b expected 1 0", c, mem_req, mem_we); end
            n_chk++; if (mem_addr !== 16'd2) begin n_fail++; $display("FAIL rd_c%0d_addr: got %0d expected 2", c, mem_addr); end
            n_chk++; if (SRAM_ready !== 1'b0) begin n_fail++; $display("FAIL rd_c%0d_ready: got %b expected 0", c, SRAM_ready); end
            n_chk++; if (WB_EN !== 1'b0) begin n_fail++; $display("FAIL rd_c%0d_hold: got WB_EN %b expected 0", c, WB_EN); end
        end
        @(posedge clk); #1;
        n_chk++; if (SRAM_ready !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rd_c4_done: got ready=%b req=%b expected 1 0", SRAM_ready, mem_req); end
        @(posedge clk); #1;
        n_chk++; if (MEM_read_value !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_value: got %h expected deadbeef", MEM_read_value); end
        n_chk++; if ({WB_EN, MEM_R_EN} !== 2'b11) begin n_fail++; $display("FAIL rd_ctrl: got %b expected 11", {WB_EN, MEM_R_EN}); end
        n_chk++; if (ALU_result !== 32'd1032 || PC !== 32'h100 || Dest !== 4'd5) begin
            n_fail++; $display("FAIL rd_fields: got %0d %h %0d expected 1032 100 5", ALU_result, PC, Dest);
        end
        clr();
    endtask

    task automatic test_non_mem();
        clr(); WB_EN_IN = 1; ALU_result_IN = 32'h55; PC_IN = 32'h4; Dest_IN = 4'd3;
        #1;
        n_chk++; if (SRAM_ready !== 1'b1) begin n_fail++; $display("FAIL nm_ready: got %b expected 1", SRAM_ready); end
        @(posedge clk); #1;
        n_chk++; if (WB_EN !== 1'b1 || MEM_R_EN !== 1'b0 || ALU_result !== 32'h55 || MEM_read_value !== 0) begin
            n_fail++; $display("FAIL nm_load: got %b %b %h %h expected 1 0 55 0", WB_EN, MEM_R_EN, ALU_result, MEM_read_value);
        end
        ALU_result_IN = 32'h66;
        @(posedge clk); #1;
        n_chk++; if (ALU_result !== 32'h66) begin n_fail++; $display("FAIL nm_next: got %h expected 66", ALU_result); end
        freeze = 1; ALU_result_IN = 32'h77;
        @(posedge clk); #1;
        n_chk++; if (ALU_result !== 32'h66) begin n_fail++; $display("FAIL nm_freeze: got %h expected 66", ALU_result); end
        clr();
    endtask

    task automatic test_flush();
        clr(); WB_EN_IN = 1; ALU_result_IN = 32'h1234; PC_IN = 32'h8; flush = 1;
        @(posedge clk); #1;
        n_chk++; if (WB_EN !== 1'b0) begin n_fail++; $display("FAIL flush_wb: got %b expected 0", WB_EN); end
        n_chk++; if (ALU_result !== 32'h1234 || PC !== 32'h8) begin n_fail++; $display("FAIL flush_data: got %h %h expected 1234 8", ALU_result, PC); end
        clr();
    endtask

    task automatic test_freeze_done();
        int r0;
        r0 = req_cycles;
        clr(); MEM_R_EN_IN = 1; WB_EN_IN = 1; ALU_result_IN = 1036; PC_IN = 32'h30;
        repeat (4) begin @(posedge clk); #1; end
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_chk++; if (SRAM_ready !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL frz%0d_state: got ready=%b req=%b expected 1 0", i, SRAM_ready, mem_req); end
            n_chk++; if (MEM_R_EN !== 1'b0) begin n_fail++; $display("FAIL frz%0d_hold: got MEM_R_EN %b expected 0", i, MEM_R_EN); end
        end
        freeze = 0;
        @(posedge clk); #1;
        n_chk++; if (MEM_read_value !== 32'hCAFE0003 || MEM_R_EN !== 1'b1 || PC !== 32'h30) begin
            n_fail++; $display("FAIL frz_load: got %h %b %h expected cafe0003 1 30", MEM_read_value, MEM_R_EN, PC);
        end
        clr();
        @(posedge clk); #1;
        n_chk++; if (req_cycles - r0 !== 3) begin n_fail++; $display("FAIL frz_req_cycles: got %0d expected 3", req_cycles - r0); end
    endtask

    task automatic test_reset_mid();
        clr(); MEM_R_EN_IN = 1; WB_EN_IN = 1; ALU_result_IN = 1032; PC_IN = 32'h40; Dest_IN = 4'd7;
        @(posedge clk); #1;
        n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got %b expected 1", mem_req); end
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_abort: got %b expected 0", mem_req); end
        n_chk++; if (WB_EN !== 1'b0 || PC !== 0 || Dest !== 0) begin n_fail++; $display("FAIL rmid_noload: got %b %h %h expected 0 0 0", WB_EN, PC, Dest); end
        rst = 0; clr();
        @(posedge clk); #1;
        n_chk++; if (mem_req !== 1'b0 || SRAM_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_idle: got req=%b ready=%b expected 0 1", mem_req, SRAM_ready); end
    endtask

    task automatic test_store_load();
        int n;
        bit st, ok;
        logic rdy;
        clr(); MEM_W_EN_IN = 1; ALU_result_IN = 1028; Val_Rm = 32'hA5A55A5A; PC_IN = 32'h10;
        st = 1; ok = 0; n = 0;
        #1;
        n_chk++; if (SRAM_ready !== WBUF) begin n_fail++; $display("FAIL st_ready: got %b expected %b", SRAM_ready, WBUF); end
        while (!ok && n < 30) begin
            rdy = SRAM_ready;
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                n_chk++; if (mem_we !== 1'b1 || mem_addr !== 16'd1 || mem_wdata !== 32'hA5A55A5A) begin
                    n_fail++; $display("FAIL st_bus: got we=%b addr=%0d data=%h expected 1 1 a5a55a5a", mem_we, mem_addr, mem_wdata);
                end
            end
            if (st && rdy) begin
                n_chk++; if (PC !== 32'h10 || n !== (WBUF ? 1 : 5)) begin n_fail++; $display("FAIL st_retire: got pc=%h edge=%0d expected 10 %0d", PC, n, WBUF ? 1 : 5); end
                st = 0; MEM_W_EN_IN = 0; MEM_R_EN_IN = 1; WB_EN_IN = 1; Val_Rm = 0; PC_IN = 32'h20;
            end else if (!st && MEM_R_EN === 1'b1) ok = 1;
        end
        n_chk++; if (!ok || n !== (WBUF ? 9 : 10)) begin n_fail++; $display("FAIL ld_latency: got ok=%b edge=%0d expected 1 %0d", ok, n, WBUF ? 9 : 10); end
        n_chk++; if (MEM_read_value !== 32'hA5A55A5A || PC !== 32'h20) begin n_fail++; $display("FAIL ld_value: got %h pc=%h expected a5a55a5a 20", MEM_read_value, PC); end
        clr();
    endtask

    initial begin
        rst = 0; clr();
        test_reset();
        test_blocking_read();
        test_non_mem();
        test_flush();
        test_freeze_done();
        test_reset_mid();
        test_store_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
